// File: rtl/ysyx_23060025_rd_arbiter_pkg.sv
// Shared encodings for the I/D read-channel arbiter: AXI constants, FSM states, requester ids.
package ysyx_23060025_rd_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/ysyx_23060025_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side not granted last.
module ysyx_23060025_rr_arb2
  import ysyx_23060025_rd_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_id
);

  always_comb begin
    o_valid = |i_req;
    o_id    = REQ_I;
    case (i_req)
      2'b01:   o_id = REQ_I;
      2'b10:   o_id = REQ_D;
      2'b11:   o_id = ~i_last_grant;
      default: o_id = REQ_I;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_rd_arbiter.sv
// Shares one AXI4 read channel between icache and dcache: grants, issues AR, demuxes R beats back
// to the owner combinationally, and flags protocol errors in a sticky bit.
module ysyx_23060025_rd_arbiter
  import ysyx_23060025_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic [2:0]            i_rsize,
  input  logic [LEN_W-1:0]      i_rlen,
  output logic                  i_rvalid,
  output logic                  i_rlast,
  output logic [DATA_WIDTH-1:0] i_rdata,

  input  logic                  d_rd_req,
  input  logic [ADDR_WIDTH-1:0] d_raddr,
  input  logic [2:0]            d_rsize,
  input  logic [LEN_W-1:0]      d_rlen,
  output logic                  d_rvalid,
  output logic                  d_rlast,
  output logic [DATA_WIDTH-1:0] d_rdata,

  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic [LEN_W-1:0]      arlen,
  output logic [1:0]            arburst,

  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  input  logic [1:0]            rresp,

  output logic                  rd_err
);

  logic [1:0]            r_state;
  logic                  r_owner;
  logic                  r_last_grant;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [2:0]            r_arsize;
  logic [LEN_W-1:0]      r_arlen;
  logic                  r_rd_err;

  logic                  w_gnt_vld;
  logic                  w_gnt_id;
  logic                  w_in_data;
  logic                  w_sel_i;
  logic                  w_sel_d;

  // A beat is bad on a non-OKAY response or when rlast disagrees with the counted burst length.
  function automatic logic beat_err(input logic [1:0] resp, input logic last,
                                    input logic [LEN_W-1:0] cnt, input logic [LEN_W-1:0] len);
    return (resp != AXI_RESP_OKAY) || (last && (cnt != len)) || (!last && (cnt == len));
  endfunction

  ysyx_23060025_rr_arb2 u_rr_arb2 (
    .i_req        ({d_rd_req, i_rd_req}),
    .i_last_grant (r_last_grant),
    .o_valid      (w_gnt_vld),
    .o_id         (w_gnt_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= REQ_I;
      r_last_grant <= REQ_I;
      r_beat_cnt   <= '0;
      r_araddr     <= '0;
      r_arsize     <= '0;
      r_arlen      <= '0;
      r_rd_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_state      <= ST_ADDR;
            r_owner      <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_araddr     <= (w_gnt_id == REQ_D) ? d_raddr : i_raddr;
            r_arsize     <= (w_gnt_id == REQ_D) ? d_rsize : i_rsize;
            r_arlen      <= (w_gnt_id == REQ_D) ? d_rlen  : i_rlen;
          end
        end
        ST_ADDR: begin
          if (arready) begin
            r_state    <= ST_DATA;
            r_beat_cnt <= '0;
          end
        end
        ST_DATA: begin
          // Only rlast ends the burst; a length mismatch is flagged but the owner keeps the channel.
          if (rvalid) begin
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            if (beat_err(rresp, rlast, r_beat_cnt, r_arlen)) r_rd_err <= 1'b1;
            if (rlast) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign arvalid = (r_state == ST_ADDR);
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arlen   = r_arlen;
  assign arburst = AXI_BURST_INCR;

  assign w_in_data = (r_state == ST_DATA);
  assign rready    = w_in_data;
  assign w_sel_i   = w_in_data && (r_owner == REQ_I);
  assign w_sel_d   = w_in_data && (r_owner == REQ_D);

  assign i_rvalid = w_sel_i & rvalid;
  assign i_rlast  = w_sel_i & rlast;
  assign i_rdata  = w_sel_i ? rdata : '0;
  assign d_rvalid = w_sel_d & rvalid;
  assign d_rlast  = w_sel_d & rlast;
  assign d_rdata  = w_sel_d ? rdata : '0;

  assign rd_err = r_rd_err;

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Randomized bench for the I/D read arbiter: acts as both caches and the AXI slave, predicting
// grants, AR fields, beat routing and the sticky error flag from a transaction-level model.
module tb_ysyx_23060025_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        i_rd_req = 1'b0;
  logic [31:0] i_raddr  = '0;
  logic [2:0]  i_rsize  = '0;
  logic [7:0]  i_rlen   = '0;
  logic        i_rvalid, i_rlast;
  logic [31:0] i_rdata;

  logic        d_rd_req = 1'b0;
  logic [31:0] d_raddr  = '0;
  logic [2:0]  d_rsize  = '0;
  logic [7:0]  d_rlen   = '0;
  logic        d_rvalid, d_rlast;
  logic [31:0] d_rdata;

  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic [1:0]  rresp = '0;
  logic        rd_err;

  int n_chk = 0;
  int n_err = 0;
  bit m_last = 1'b0;   // last granted side: 0 = I, 1 = D
  bit m_err  = 1'b0;

  ysyx_23060025_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_W(8)) dut (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_raddr(i_raddr), .i_rsize(i_rsize), .i_rlen(i_rlen),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_raddr(d_raddr), .d_rsize(d_rsize), .d_rlen(d_rlen),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
    .rd_err(rd_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at an IDLE cycle just after requests were driven: one idle negedge, then AR next cycle.
  task automatic wait_ar();
    int n;
    @(negedge clock);
    check("idle_bubble", {arvalid, rready}, 2'b00);
    check("rd_err", rd_err, m_err);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!arvalid && n < 4);
    check("ar_latency", n, 1);
  endtask

  task automatic do_round(input bit ni, input bit nd,
                          input logic [31:0] a_i, input logic [31:0] a_d,
                          input logic [7:0] l_i, input logic [7:0] l_d,
                          input logic [2:0] s_i, input logic [2:0] s_d,
                          input int ar_dly, input int emode, input int eidx,
                          input bit drop_addr, output bit obs_d);
    bit win, stop, rl;
    logic [31:0] ea, dat;
    logic [7:0]  el;
    logic [2:0]  es;
    logic [1:0]  rs;
    int b, gap, em, ei;
    obs_d = 1'b0;
    if (ni && !i_rd_req) begin i_rd_req = 1'b1; i_raddr = a_i; i_rlen = l_i; i_rsize = s_i; end
    if (nd && !d_rd_req) begin d_rd_req = 1'b1; d_raddr = a_d; d_rlen = l_d; d_rsize = s_d; end
    if (!i_rd_req && !d_rd_req) return;
    win    = (i_rd_req && d_rd_req) ? !m_last : d_rd_req;
    m_last = win;
    ea = win ? d_raddr : i_raddr;
    el = win ? d_rlen  : i_rlen;
    es = win ? d_rsize : i_rsize;
    em = emode;
    ei = eidx;
    if (em == 1 && el == 0) em = 0;
    if (em == 1 && ei >= int'(el)) ei = int'(el) - 1;

    wait_ar();
    obs_d = (araddr == d_raddr) && d_rd_req;
    check("ar_fields", {araddr, arlen, arsize, arburst}, {ea, el, es, 2'b01});

    for (int k = 0; k <= ar_dly; k++) begin
      @(posedge clock); #1;
      if (k == 0 && drop_addr) begin
        if (win) d_rd_req = 1'b0; else i_rd_req = 1'b0;
      end
      arready = (k == ar_dly);
      @(negedge clock);
      check("ar_hold", {arvalid, araddr, arlen}, {1'b1, ea, el});
    end
    @(posedge clock); #1;
    arready = 1'b0;

    b = 0;
    stop = 1'b0;
    while (!stop) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        check("gap_quiet", {i_rvalid, d_rvalid, rready}, 3'b001);
        @(posedge clock); #1;
      end
      dat = $urandom;
      rs  = (em == 3 && b == 0) ? 2'b10 : 2'b00;
      case (em)
        1:       rl = (b == ei);
        2:       rl = (b == int'(el) + 1);
        default: rl = (b == int'(el));
      endcase
      rvalid = 1'b1; rdata = dat; rlast = rl; rresp = rs;
      if (rs != 2'b00 || (rl && b != int'(el)) || (!rl && b == int'(el))) m_err = 1'b1;
      @(negedge clock);
      if (win) begin
        check("d_beat", {d_rvalid, d_rlast, d_rdata}, {1'b1, rl, dat});
        check("i_quiet", {i_rvalid, i_rlast}, 2'b00);
      end else begin
        check("i_beat", {i_rvalid, i_rlast, i_rdata}, {1'b1, rl, dat});
        check("d_quiet", {d_rvalid, d_rlast}, 2'b00);
      end
      check("rready", rready, 1'b1);
      stop = rl;
      b++;
      @(posedge clock); #1;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
    if (win) d_rd_req = 1'b0; else i_rd_req = 1'b0;
  endtask

  task automatic rand_round(input bit allow_err);
    bit ni, nd, od;
    int em;
    ni = $urandom_range(0, 1);
    nd = $urandom_range(0, 1);
    if (!ni && !nd && !i_rd_req && !d_rd_req) ni = 1'b1;
    em = (allow_err && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    do_round(ni, nd, $urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc,
             8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
             3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)),
             $urandom_range(0, 3), em, $urandom_range(0, 6), ($urandom_range(0, 5) == 0), od);
  endtask

  task automatic flush();
    bit od;
    for (int k = 0; k < 2; k++)
      if (i_rd_req || d_rd_req) do_round(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, od);
  endtask

  task automatic reset_mid_data();
    flush();
    i_rd_req = 1'b1; i_raddr = 32'h2000_0040; i_rlen = 8'd3; i_rsize = 3'd2;
    m_last = 1'b0;
    wait_ar();
    @(posedge clock); #1;
    arready = 1'b1;
    @(posedge clock); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef; rlast = 1'b0;
    @(negedge clock);
    check("rst_pre_beat", i_rvalid, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("rst_ctrl", {arvalid, rready, i_rvalid, d_rvalid, i_rlast, rd_err}, 6'b0);
    check("rst_ar", {araddr, arlen, arsize}, 43'd0);
    check("rst_rdata", i_rdata, 32'd0);
    rvalid = 1'b0; i_rd_req = 1'b0;
    m_last = 1'b0; m_err = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    bit od;
    bit exp_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    #12;
    check("reset_ctrl", {arvalid, rready, i_rvalid, d_rvalid, i_rlast, d_rlast, rd_err}, 7'b0);
    check("reset_ar", {araddr, arlen, arsize}, 43'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // single D burst
    do_round(0, 1, 0, 32'h8000_0010, 0, 8'd3, 0, 3'd2, 2, 0, 0, 1'b0, od);

    // contention: last grant starts at D after the burst above, so reset history first
    reset_mid_data();
    for (int k = 0; k < 6; k++) begin
      do_round(1, 1, 32'h1000_0100, 32'h8000_0200, 8'd1, 8'd1, 3'd2, 3'd2,
               1, 0, 0, 1'b0, od);
      check("grant_seq", od, exp_seq[k]);
    end
    flush();

    // uncached I read, then I request dropped during ADDR
    do_round(1, 0, 32'h1000_0000, 0, 8'd0, 0, 3'd0, 0, 0, 0, 0, 1'b0, od);
    do_round(1, 0, 32'h1000_0080, 0, 8'd2, 0, 3'd2, 0, 3, 0, 0, 1'b1, od);

    for (int k = 0; k < 30; k++) rand_round(1'b0);
    flush();

    // early rlast (on second beat of a 4-beat burst), then an error response
    do_round(0, 1, 0, 32'h8000_1000, 0, 8'd3, 0, 3'd2, 0, 1, 1, 1'b0, od);
    reset_mid_data();
    do_round(1, 0, 32'h1000_2000, 0, 8'd3, 0, 3'd2, 0, 1, 3, 0, 1'b0, od);

    for (int k = 0; k < 30; k++) rand_round(1'b1);
    reset_mid_data();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
